// File: rtl/cp0_timer_pkg.sv
// Shared timer definitions: register offsets, FSM states, mode codes and bridge base addresses.
package cp0_timer_pkg;

  localparam logic [1:0] TIMER_CTRL    = 2'b00;
  localparam logic [1:0] TIMER_PRESET  = 2'b01;
  localparam logic [1:0] TIMER_COUNT   = 2'b10;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  localparam logic [31:0] TIMER0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE  = 32'h0000_7F10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StCnt  = 2'b10,
    StInt  = 2'b11
  } timer_state_e;

  // Only mode 01 reloads; the unused codes 10/11 fall back to one-shot.
  function automatic logic is_periodic(input logic [1:0] mode);
    return mode == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Memory-mapped countdown timer (one-shot / periodic) driving CP0 HWInt[0].
module cp0_timer
  import cp0_timer_pkg::*;
#(
  parameter int unsigned           DATA_W    = 32,
  parameter logic [DATA_W-1:0]     CNT_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  localparam logic [DATA_W-1:0] CntOne = DATA_W'(1);

  logic [3:0]        r_ctrl;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] r_count;
  logic              r_irq_flag;
  timer_state_e      r_state;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_kill;
  logic w_unused_addr;

  assign w_wr_ctrl     = WE && (Addr[3:2] == TIMER_CTRL);
  assign w_wr_preset   = WE && (Addr[3:2] == TIMER_PRESET);
  // A disabling CTRL write pre-empts whatever the FSM would do this edge.
  assign w_kill        = w_wr_ctrl && !Din[0];
  assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign IRQ = r_ctrl[3] & r_irq_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= 4'h0;
      r_preset   <= CNT_RESET;
      r_count    <= CNT_RESET;
      r_irq_flag <= 1'b0;
      r_state    <= StIdle;
    end else begin
      if (w_wr_preset) begin
        r_preset <= Din;
      end

      if (w_kill) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (r_ctrl[0]) begin
              r_irq_flag <= 1'b0;
              r_state    <= StLoad;
            end
          end
          StLoad: begin
            r_count    <= r_preset;
            r_irq_flag <= 1'b0;
            r_state    <= StCnt;
          end
          StCnt: begin
            if (!r_ctrl[0]) begin
              r_state <= StIdle;
            end else if (r_count > CntOne) begin
              r_count <= r_count - CntOne;
            end else begin
              r_count    <= '0;
              r_irq_flag <= 1'b1;
              r_state    <= StInt;
            end
          end
          StInt: begin
            // Periodic keeps the flag through IDLE; it drops on entry to LOAD.
            if (!is_periodic(r_ctrl[2:1])) begin
              r_ctrl[0] <= 1'b0;
            end
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end

      if (w_wr_ctrl) begin
        r_ctrl <= Din[3:0];
      end
    end
  end

  always_comb begin
    Dout = '0;
    unique case (Addr[3:2])
      TIMER_CTRL:   Dout = {{(DATA_W-4){1'b0}}, r_ctrl};
      TIMER_PRESET: Dout = r_preset;
      TIMER_COUNT:  Dout = r_count;
      default:      Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer.sv
// Scoreboarded bench for cp0_timer: expected reads queued at stimulus time, checked cycle by cycle.
module tb_cp0_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] dout;
    logic        irq;
    logic        chk_irq;
  } exp_t;

  exp_t sb_q[$];

  cp0_timer #(
    .DATA_W    (32),
    .CNT_RESET (32'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] addr, input logic [31:0] dout,
                      input logic irq, input logic chk_irq);
    exp_t e;
    e.tag     = tag;
    e.addr    = addr;
    e.dout    = dout;
    e.irq     = irq;
    e.chk_irq = chk_irq;
    sb_q.push_back(e);
  endtask

  // One queue entry per clock: entry k is the state just after edge E_k.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      Addr = e.addr;
      #1;
      check_eq(e.tag, Dout, e.dout);
      if (e.chk_irq) check_eq({e.tag, "/irq"}, {31'd0, IRQ}, {31'd0, e.irq});
      @(posedge clk);
      #1;
    end
  endtask

  // Write lands on edge E_0; returns just after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    WE    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Countdown trace for a single run with PRESET p started by the CTRL write at E_0.
  function automatic logic [31:0] os_count(input int k, input int p);
    if (k < 2) return 32'd0;
    if (k < 2 + p) return 32'(p - (k - 2));
    return 32'd0;
  endfunction

  initial begin
    do_reset();

    // Reset values and CTRL upper-bit masking
    push("rst_ctrl",   32'h0, 32'h0, 1'b0, 1'b1);
    push("rst_preset", 32'h4, 32'h0, 1'b0, 1'b1);
    push("rst_count",  32'h8, 32'h0, 1'b0, 1'b1);
    drain();
    wr(32'h0, 32'hFFFF_FFFF);
    push("ctrl_mask", 32'h0, 32'h0000_000F, 1'b0, 1'b1);
    drain();

    // One-shot, PRESET=5
    do_reset();
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    for (int k = 0; k < 12; k++) begin
      push($sformatf("os_k%0d", k), 32'h8, os_count(k, 5), (k >= 7), 1'b1);
    end
    push("os_ctrl_after", 32'h0, 32'h8, 1'b1, 1'b1);
    drain();
    wr(32'h0, 32'h9);
    push("os_re_preset", 32'h4, 32'd5, 1'b0, 1'b0);
    push("os_re_load",   32'h8, 32'd0, 1'b0, 1'b1);
    push("os_re_cnt",    32'h8, 32'd5, 1'b0, 1'b1);
    drain();

    // Periodic, PRESET=3: period of 6 from E_2, IRQ on INT and IDLE
    do_reset();
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int k = 0; k < 20; k++) begin
      int p;
      logic [31:0] c;
      logic        q;
      p = (k - 2) % 6;
      c = 32'd0;
      q = 1'b0;
      if (k >= 2 && p < 3) c = 32'(3 - p);
      if (k >= 2 && (p == 3 || p == 4)) q = 1'b1;
      push($sformatf("per_k%0d", k), 32'h8, c, q, 1'b1);
    end
    drain();

    // Masked expiry, then unmask via a new LOAD
    do_reset();
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      push($sformatf("msk_k%0d", k), 32'h8, os_count(k, 2), 1'b0, 1'b1);
    end
    drain();
    wr(32'h0, 32'h9);
    for (int k = 0; k < 6; k++) begin
      push($sformatf("msk_re_k%0d", k), 32'h8, os_count(k, 2), (k >= 4), (k >= 1));
    end
    drain();

    // Disable freezes COUNT; writes to COUNT / reserved are ignored
    do_reset();
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      push($sformatf("dis_k%0d", k), 32'h8, os_count(k, 10), 1'b0, 1'b1);
    end
    drain();
    wr(32'h0, 32'h0);
    for (int k = 0; k < 4; k++) push($sformatf("dis_frz%0d", k), 32'h8, 32'd7, 1'b0, 1'b1);
    drain();
    wr(32'h8, 32'd123);
    push("dis_cnt_wr", 32'h8, 32'd7, 1'b0, 1'b1);
    push("dis_preset", 32'h4, 32'd10, 1'b0, 1'b1);
    push("dis_ctrl",   32'h0, 32'h0, 1'b0, 1'b1);
    drain();
    wr(32'hC, 32'd55);
    push("rsvd_rd", 32'hC, 32'h0, 1'b0, 1'b1);
    drain();

    // PRESET=0 behaves like PRESET=1
    do_reset();
    wr(32'h0, 32'h9);
    for (int k = 0; k < 5; k++) begin
      push($sformatf("p0_k%0d", k), 32'h8, 32'd0, (k >= 3), 1'b1);
    end
    drain();

    // Reset mid-count at COUNT=4
    do_reset();
    wr(32'h4, 32'd6);
    wr(32'h0, 32'h9);
    for (int k = 0; k < 4; k++) begin
      push($sformatf("mid_k%0d", k), 32'h8, os_count(k, 6), 1'b0, 1'b1);
    end
    drain();
    Addr = 32'h8;
    #1;
    check_eq("mid_pre_rst", Dout, 32'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      push($sformatf("mid_post%0d", k), (k % 2 == 0) ? 32'h8 : 32'h0, 32'd0, 1'b0, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
